// File: rtl/barrel_collision_if.sv
// Bus between the barrel/donkey position sources and the game-state consumers.
// The game-control and position inputs flow master -> slave. The hit, lives
// and status outputs flow slave -> master.
//   start_game, animation, frame_start : game control / frame trigger
//   xpos, ypos                         : donkey top-left corner
//   barrel, xpos_barrel, ypos_barrel   : per-slot active flag and top-left corner
//   hit, hit_index, lives, invuln, game_over : collision results
interface barrel_collision_if #(
  parameter int BARRELS = 10
);
  logic                     start_game;
  logic                     animation;
  logic                     frame_start;
  logic [10:0]              xpos;
  logic [10:0]              ypos;
  logic [BARRELS-1:0]       barrel;
  logic [BARRELS-1:0][10:0] xpos_barrel;
  logic [BARRELS-1:0][10:0] ypos_barrel;
  logic                     hit;
  logic [3:0]               hit_index;
  logic [1:0]               lives;
  logic                     invuln;
  logic                     game_over;

  modport master (
    output start_game, animation, frame_start, xpos, ypos,
           barrel, xpos_barrel, ypos_barrel,
    input  hit, hit_index, lives, invuln, game_over
  );

  modport slave (
    input  start_game, animation, frame_start, xpos, ypos,
           barrel, xpos_barrel, ypos_barrel,
    output hit, hit_index, lives, invuln, game_over
  );
endinterface

// File: rtl/barrel_collision.sv
// Per-frame donkey/barrel hit detection with a lives counter, a post-hit
// invulnerability window and a sticky game-over flag.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : barrel_collision_if slave (inputs: game control and positions;
//         outputs: hit, hit_index, lives, invuln, game_over)
//
// state  | meaning
// IDLE   | game not running; lives held at LIVES
// ARMED  | waiting for frame_start
// SCAN   | testing one barrel slot per cycle, idx 0..BARRELS-1
// DECIDE | apply the result of the scan (at most one life lost)
// INVULN | post-hit window; frame_start ignored
// OVER   | lives exhausted; only rst leaves
module barrel_collision #(
  parameter int BARRELS     = 10,
  parameter int DONKEY_W    = 48,
  parameter int DONKEY_H    = 64,
  parameter int BARREL_SIZE = 32,
  parameter int LIVES       = 3,
  parameter int INVULN_TIME = 65_000_000
) (
  input  logic             clk,
  input  logic             rst,
  barrel_collision_if.slave bus
);

  localparam int         CNT_W    = $clog2(INVULN_TIME + 1);
  localparam [CNT_W-1:0] CNT_INIT = CNT_W'(INVULN_TIME - 1);
  localparam [3:0]       IDX_LAST = 4'(BARRELS - 1);
  localparam [1:0]       LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SCAN, S_DECIDE, S_INVULN, S_OVER
  } state_t;

  state_t           r_state;
  logic [3:0]       r_idx;
  logic             r_any;
  logic [3:0]       r_first_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic [3:0]       r_hit_index;
  logic [1:0]       r_lives;
  logic             r_invuln;
  logic             r_game_over;

  logic [10:0] w_xb;
  logic [10:0] w_yb;
  logic        w_ovl;
  logic        w_abort;

  // 12-bit sums so a box near the right/bottom edge cannot wrap. Strict
  // compares make touching edges a miss.
  assign w_xb  = bus.xpos_barrel[r_idx];
  assign w_yb  = bus.ypos_barrel[r_idx];
  assign w_ovl = bus.barrel[r_idx]
              && ({1'b0, bus.xpos} < ({1'b0, w_xb} + 12'(BARREL_SIZE)))
              && ({1'b0, w_xb}     < ({1'b0, bus.xpos} + 12'(DONKEY_W)))
              && ({1'b0, bus.ypos} < ({1'b0, w_yb} + 12'(BARREL_SIZE)))
              && ({1'b0, w_yb}     < ({1'b0, bus.ypos} + 12'(DONKEY_H)));

  assign w_abort = !bus.start_game || bus.animation;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_any       <= 1'b0;
      r_first_idx <= '0;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_hit_index <= '0;
      r_lives     <= LIVES_INIT;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      // Leaving the game (or entering the intro) wins over everything except
      // the terminal state, including a hit being decided this cycle.
      if (r_state != S_OVER && w_abort) begin
        r_state  <= S_IDLE;
        r_lives  <= LIVES_INIT;
        r_invuln <= 1'b0;
        r_cnt    <= '0;
        r_idx    <= '0;
        r_any    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_lives <= LIVES_INIT;
            r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (bus.frame_start) begin
              r_idx   <= '0;
              r_any   <= 1'b0;
              r_state <= S_SCAN;
            end
          end
          S_SCAN: begin
            // Slots are scanned upward, so the first overlap is the lowest.
            if (w_ovl && !r_any) begin
              r_any       <= 1'b1;
              r_first_idx <= r_idx;
            end
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= S_DECIDE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
          S_DECIDE: begin
            if (r_any) begin
              r_hit       <= 1'b1;
              r_hit_index <= r_first_idx;
              if (r_lives <= 2'd1) begin
                r_lives     <= 2'd0;
                r_game_over <= 1'b1;
                r_state     <= S_OVER;
              end else begin
                r_lives  <= r_lives - 2'd1;
                r_invuln <= 1'b1;
                r_cnt    <= CNT_INIT;
                r_state  <= S_INVULN;
              end
            end else begin
              r_state <= S_ARMED;
            end
          end
          S_INVULN: begin
            if (r_cnt == '0) begin
              r_invuln <= 1'b0;
              r_state  <= S_ARMED;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_OVER: begin
            r_state <= S_OVER;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.hit       = r_hit;
  assign bus.hit_index = r_hit_index;
  assign bus.lives     = r_lives;
  assign bus.invuln    = r_invuln;
  assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_barrel_collision.sv
module tb_barrel_collision;
  localparam int NB  = 10;
  localparam int INV = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    int idx;
    int lives;
    int cyc;
  } exp_t;
  exp_t q[$];

  barrel_collision_if #(.BARRELS(NB)) bus ();

  barrel_collision #(
    .BARRELS(NB), .DONKEY_W(48), .DONKEY_H(64), .BARREL_SIZE(32),
    .LIVES(3), .INVULN_TIME(INV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every hit pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.hit) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_hit: got hit=1 idx=%0d at cycle %0d expected no hit",
                 bus.hit_index, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hit_index", int'(bus.hit_index), e.idx);
        chk("hit_lives", int'(bus.lives), e.lives);
        chk("hit_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic clr_barrels();
    bus.barrel      = '0;
    bus.xpos_barrel = '0;
    bus.ypos_barrel = '0;
  endtask

  task automatic set_slot(input int k, input int x, input int y);
    bus.barrel[k]      = 1'b1;
    bus.xpos_barrel[k] = 11'(x);
    bus.ypos_barrel[k] = 11'(y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start();
    bus.start_game = 1'b1;
    bus.animation  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One frame scan. A hit expectation is queued with its exact cycle; with
  // wait_inv the invulnerability window is measured and a stray frame_start
  // is injected inside it.
  task automatic frame(input bit exp_hit, input int exp_idx, input int exp_lives,
                       input bit wait_inv);
    int c_hi;
    @(negedge clk);
    bus.frame_start = 1'b1;
    if (exp_hit) q.push_back('{exp_idx, exp_lives, cyc + NB + 2});
    @(negedge clk);
    bus.frame_start = 1'b0;
    if (exp_hit && wait_inv) begin
      c_hi = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (bus.invuln) c_hi++;
        else if (c_hi > 0) break;
        if (i == 20) begin
          bus.frame_start = 1'b1;
          @(negedge clk);
          bus.frame_start = 1'b0;
          if (bus.invuln) c_hi++;
        end
      end
      chk("invuln_len", c_hi, INV);
    end else begin
      repeat (NB + 4) @(negedge clk);
    end
    if (exp_hit) chk("pending_hits", q.size(), 0);
  endtask

  initial begin
    bus.start_game  = 1'b0;
    bus.animation   = 1'b0;
    bus.frame_start = 1'b0;
    bus.xpos        = 11'd100;
    bus.ypos        = 11'd200;
    clr_barrels();

    // Reset values
    do_reset();
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_hit_index", int'(bus.hit_index), 0);
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_invuln", int'(bus.invuln), 0);
    chk("rst_game_over", int'(bus.game_over), 0);

    // No barrels active: five frames, no hit
    start();
    for (int f = 0; f < 5; f++) frame(1'b0, 0, 0, 1'b0);
    chk("idle_lives", int'(bus.lives), 3);
    chk("idle_game_over", int'(bus.game_over), 0);

    // Single overlap in slot 3
    set_slot(3, 130, 220);
    frame(1'b1, 3, 2, 1'b1);
    chk("after_hit_invuln", int'(bus.invuln), 0);

    // Touching edges do not collide; one pixel inside does
    clr_barrels();
    set_slot(0, 148, 200);
    frame(1'b0, 0, 0, 1'b0);
    clr_barrels();
    set_slot(0, 100, 264);
    frame(1'b0, 0, 0, 1'b0);
    chk("touch_lives", int'(bus.lives), 2);
    clr_barrels();
    set_slot(5, 147, 263);
    frame(1'b1, 5, 1, 1'b1);

    // Slots 2 and 7 overlap, slot 1 overlaps but is inactive
    do_reset();
    chk("rst2_lives", int'(bus.lives), 3);
    start();
    clr_barrels();
    set_slot(2, 110, 210);
    set_slot(7, 120, 230);
    bus.barrel[1]      = 1'b0;
    bus.xpos_barrel[1] = 11'd105;
    bus.ypos_barrel[1] = 11'd205;
    frame(1'b1, 2, 2, 1'b1);

    // Continue to game over
    frame(1'b1, 2, 1, 1'b1);
    frame(1'b1, 2, 0, 1'b0);
    chk("over_game_over", int'(bus.game_over), 1);
    chk("over_invuln", int'(bus.invuln), 0);
    chk("over_lives", int'(bus.lives), 0);
    frame(1'b0, 0, 0, 1'b0);
    frame(1'b0, 0, 0, 1'b0);
    bus.start_game = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_sticky", int'(bus.game_over), 1);
    chk("over_lives_held", int'(bus.lives), 0);
    bus.start_game = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    chk("rst3_game_over", int'(bus.game_over), 0);
    chk("rst3_lives", int'(bus.lives), 3);

    // Reset mid-scan (idx 5) with slot 2 overlap already flagged
    start();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midscan_lives", int'(bus.lives), 3);
    chk("midscan_invuln", int'(bus.invuln), 0);
    chk("midscan_hit_index", int'(bus.hit_index), 0);

    // Animation during invulnerability returns to IDLE and reloads lives
    frame(1'b1, 2, 2, 1'b0);
    chk("anim_pre_invuln", int'(bus.invuln), 1);
    bus.animation = 1'b1;
    repeat (2) @(negedge clk);
    chk("anim_invuln", int'(bus.invuln), 0);
    chk("anim_lives", int'(bus.lives), 3);
    repeat (20) @(negedge clk);
    chk("anim_no_hit_lives", int'(bus.lives), 3);
    bus.animation = 1'b0;
    repeat (2) @(negedge clk);
    frame(1'b1, 2, 2, 1'b1);

    chk("final_pending", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
